// File: rtl/ptp_ts_queue_mc.sv
// rtl/ptp_ts_queue_mc.sv - multi-channel PTP timestamp capture queue with round-robin merge into a shared FIFO

module ptp_ts_queue_mc #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 80,
  parameter int SEQ_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       cap_vld,
  input  logic [4*NUM_CH-1:0]     cap_msgtype,
  input  logic [SEQ_W*NUM_CH-1:0] cap_seq,
  input  logic [TS_W-1:0]         rtc_ts,
  input  logic                    flush,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [CH_W-1:0]         rd_ch,
  output logic [3:0]              rd_msgtype,
  output logic [SEQ_W-1:0]        rd_seq,
  output logic [TS_W-1:0]         rd_ts,
  output logic [LW-1:0]           fifo_level,
  input  logic [NUM_CH-1:0]       ovf_clr,
  output logic [NUM_CH-1:0]       ovf_sticky,
  output logic [8*NUM_CH-1:0]     drop_cnt,
  output logic                    irq
);
  localparam int EW = CH_W + 4 + SEQ_W + TS_W;

  logic [NUM_CH-1:0] hold_v;
  logic [3:0]        hold_mt  [NUM_CH];
  logic [SEQ_W-1:0]  hold_seq [NUM_CH];
  logic [TS_W-1:0]   hold_ts  [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     level;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;

  logic              gnt_v;
  logic [CH_W-1:0]   gnt_ch;
  logic              push;
  logic              pop;
  logic              space;
  logic [NUM_CH-1:0] gnt_oh;
  logic [NUM_CH-1:0] drop;

  assign rd_valid   = (level != '0);
  assign pop        = rd_valid & rd_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign space      = (level < LW'(DEPTH)) | pop;
  assign push       = gnt_v & space & ~flush;
  assign fifo_level = level;
  assign irq        = rd_valid | (|ovf_sticky);

  assign head       = mem[rptr];
  assign rd_ts      = rd_valid ? head[TS_W-1:0] : '0;
  assign rd_seq     = rd_valid ? head[TS_W +: SEQ_W] : '0;
  assign rd_msgtype = rd_valid ? head[TS_W+SEQ_W +: 4] : '0;
  assign rd_ch      = rd_valid ? head[TS_W+SEQ_W+4 +: CH_W] : '0;

  // Round-robin pick: lowest pending channel at or above rr_ptr, else lowest pending overall
  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hold_v[c]) begin
        gnt_v  = 1'b1;
        gnt_ch = CH_W'(c);
      end
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hold_v[c] && (CH_W'(c) >= rr_ptr)) gnt_ch = CH_W'(c);
    end
  end

  // Per-channel grant and drop qualifiers; captures in a flush cycle are neither stored nor counted
  always_comb begin
    gnt_oh = '0;
    drop   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gnt_oh[c] = push && (gnt_ch == CH_W'(c));
      drop[c]   = ~flush & cap_vld[c] & hold_v[c] & ~gnt_oh[c];
    end
  end

  // Holding registers: load on capture when free or when being drained this cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_v <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hold_mt[c]  <= '0;
        hold_seq[c] <= '0;
        hold_ts[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          hold_v[c] <= 1'b0;
        end else if (cap_vld[c] && (!hold_v[c] || gnt_oh[c])) begin
          hold_v[c]   <= 1'b1;
          hold_mt[c]  <= cap_msgtype[4*c +: 4];
          hold_seq[c] <= cap_seq[SEQ_W*c +: SEQ_W];
          hold_ts[c]  <= rtc_ts;
        end else if (gnt_oh[c]) begin
          hold_v[c] <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers, level and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wptr   <= wptr + 1'b1;
        rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Entry storage; contents are only observable through the valid-gated head
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {gnt_ch, hold_mt[gnt_ch], hold_seq[gnt_ch], hold_ts[gnt_ch]};
  end

  // Overflow tracking: a drop coinciding with a clear leaves exactly one counted drop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_sticky <= '0;
      drop_cnt   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (drop[c]) begin
          ovf_sticky[c] <= 1'b1;
          if (ovf_clr[c])
            drop_cnt[8*c +: 8] <= 8'd1;
          else if (drop_cnt[8*c +: 8] != 8'hFF)
            drop_cnt[8*c +: 8] <= drop_cnt[8*c +: 8] + 8'd1;
        end else if (ovf_clr[c]) begin
          ovf_sticky[c]      <= 1'b0;
          drop_cnt[8*c +: 8] <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ptp_ts_queue_mc.sv
// tb/tb_ptp_ts_queue_mc.sv - directed scoreboard bench for ptp_ts_queue_mc

module tb_ptp_ts_queue_mc;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 80;
  localparam int SEQ_W  = 16;

  typedef struct {
    logic [1:0]  ch;
    logic [3:0]  mt;
    logic [15:0] seq;
    logic [79:0] ts;
  } ent_t;

  logic        clk;
  logic        rstn;
  logic [3:0]  cap_vld;
  logic [15:0] cap_msgtype;
  logic [63:0] cap_seq;
  logic [79:0] rtc_ts;
  logic        flush;
  logic        rd_ready;
  logic        rd_valid;
  logic [1:0]  rd_ch;
  logic [3:0]  rd_msgtype;
  logic [15:0] rd_seq;
  logic [79:0] rd_ts;
  logic [3:0]  fifo_level;
  logic [3:0]  ovf_clr;
  logic [3:0]  ovf_sticky;
  logic [31:0] drop_cnt;
  logic        irq;

  int   total;
  int   bad;
  ent_t sb[$];

  ptp_ts_queue_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rstn(rstn), .cap_vld(cap_vld), .cap_msgtype(cap_msgtype), .cap_seq(cap_seq),
    .rtc_ts(rtc_ts), .flush(flush), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_ch(rd_ch),
    .rd_msgtype(rd_msgtype), .rd_seq(rd_seq), .rd_ts(rd_ts), .fifo_level(fifo_level),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle capture; spread gives each channel its own seq/msgtype; store marks expected FIFO entries
  task automatic cap(input logic [3:0] mask, input logic [15:0] seq, input logic [3:0] mt,
                     input logic [79:0] ts, input bit spread, input bit store);
    ent_t e;
    cap_vld = mask;
    rtc_ts  = ts;
    for (int c = 0; c < NUM_CH; c++) begin
      cap_seq[16*c +: 16]    = spread ? seq + 16'(c * 16'h100) : seq;
      cap_msgtype[4*c +: 4]  = spread ? mt + 4'(c) : mt;
      if (mask[c] && store) begin
        e.ch  = 2'(c);
        e.mt  = cap_msgtype[4*c +: 4];
        e.seq = cap_seq[16*c +: 16];
        e.ts  = ts;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    cap_vld = '0;
  endtask

  // Pops n entries back to back, comparing each head against the scoreboard
  task automatic drain(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      chk("pop_valid", rd_valid, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pop_ch", rd_ch, e.ch);
        chk("pop_msgtype", rd_msgtype, e.mt);
        chk("pop_seq", rd_seq, e.seq);
        chk("pop_ts", rd_ts, e.ts);
      end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    cap_vld = '0;
    cap_msgtype = '0;
    cap_seq = '0;
    rtc_ts = '0;
    flush = 1'b0;
    rd_ready = 1'b0;
    ovf_clr = '0;

    // Reset state
    step(3);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_ch", rd_ch, 2'd0);
    chk("rst_rd_msgtype", rd_msgtype, 4'd0);
    chk("rst_rd_seq", rd_seq, 16'd0);
    chk("rst_rd_ts", rd_ts, 80'd0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_sticky", ovf_sticky, 4'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    chk("rst_irq", irq, 1'b0);
    rstn = 1'b1;
    step(1);

    // Single capture: two-cycle latency, then pop empties the FIFO
    cap(4'b0010, 16'h00A7, 4'h0, 80'h0000_0000_0005_1234_5678, 1'b0, 1'b1);
    chk("single_not_yet_valid", rd_valid, 1'b0);
    step(1);
    chk("single_level", fifo_level, 4'd1);
    chk("single_irq", irq, 1'b1);
    drain(1);
    chk("single_after_pop_valid", rd_valid, 1'b0);
    chk("single_after_pop_level", fifo_level, 4'd0);

    // Simultaneous pairs from rr_ptr=0, then all four channels
    do_flush();
    cap(4'b0011, 16'h2000, 4'h2, 80'h11_0000_0001, 1'b1, 1'b1);
    step(2);
    cap(4'b0011, 16'h3000, 4'h3, 80'h22_0000_0002, 1'b1, 1'b1);
    step(3);
    chk("pairs_level", fifo_level, 4'd4);
    drain(4);
    do_flush();
    cap(4'b1111, 16'h4000, 4'h4, 80'h33_0000_0003, 1'b1, 1'b1);
    step(4);
    chk("four_level", fifo_level, 4'd4);
    drain(4);
    chk("four_drained_level", fifo_level, 4'd0);

    // Overflow: ten spaced captures on channel 0 with the host stalled
    for (int k = 1; k <= 10; k++) begin
      cap(4'b0001, 16'h0100 + 16'(k), 4'(k), {48'(k), 32'(k * 13 + 7)}, 1'b0, k <= 9);
      step(1);
    end
    chk("ovf_level", fifo_level, 4'd8);
    chk("ovf_drop_cnt0", drop_cnt[7:0], 8'd1);
    chk("ovf_sticky0", ovf_sticky[0], 1'b1);
    chk("ovf_irq", irq, 1'b1);
    drain(1);
    chk("ovf_held_enters_level", fifo_level, 4'd8);
    drain(8);
    chk("ovf_drained_level", fifo_level, 4'd0);
    ovf_clr = 4'b0001;
    step(1);
    ovf_clr = '0;
    chk("clr0_sticky", ovf_sticky, 4'b0000);
    chk("clr0_cnt", drop_cnt, 32'd0);

    // Saturation: nine back-to-back captures fill FIFO and holder, then 300 drops
    for (int k = 0; k < 9; k++)
      cap(4'b0010, 16'h5000 + 16'(k), 4'h5, {48'h5, 32'(k)}, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++)
      cap(4'b0010, 16'h6000, 4'h6, {48'h6, 32'(k)}, 1'b0, 1'b0);
    chk("sat_cnt1", drop_cnt[15:8], 8'd255);
    chk("sat_sticky1", ovf_sticky[1], 1'b1);
    chk("sat_level", fifo_level, 4'd8);
    ovf_clr = 4'b0010;
    cap(4'b0010, 16'h7000, 4'h7, 80'h7, 1'b0, 1'b0);
    ovf_clr = '0;
    chk("clr_drop_cnt1", drop_cnt[15:8], 8'd1);
    chk("clr_drop_sticky", ovf_sticky, 4'b0010);
    chk("clr_drop_cnt0", drop_cnt[7:0], 8'd0);

    // Full FIFO plus pending holder: pop and push in one cycle, no drop
    drain(1);
    chk("full_pushpop_level", fifo_level, 4'd8);
    chk("full_pushpop_no_drop", drop_cnt[15:8], 8'd1);
    drain(3);
    chk("pre_flush_level", fifo_level, 4'd5);

    // Flush with level 5 and channel 0 held; capture in the flush cycle is not counted
    cap(4'b0001, 16'h8000, 4'h8, 80'h8, 1'b0, 1'b0);
    flush = 1'b1;
    cap_vld = 4'b0001;
    step(1);
    flush = 1'b0;
    cap_vld = '0;
    sb.delete();
    chk("flush_level", fifo_level, 4'd0);
    chk("flush_valid", rd_valid, 1'b0);
    chk("flush_drop_cnt", drop_cnt, 32'h0000_0100);
    chk("flush_sticky", ovf_sticky, 4'b0010);
    step(3);
    chk("flush_holder_cleared", rd_valid, 1'b0);

    // Asynchronous reset in the middle of a burst
    cap(4'b1111, 16'h9000, 4'h9, 80'h9, 1'b1, 1'b0);
    step(1);
    chk("burst_valid", rd_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 1'b0);
    chk("arst_level", fifo_level, 4'd0);
    chk("arst_sticky", ovf_sticky, 4'd0);
    chk("arst_drop_cnt", drop_cnt, 32'd0);
    chk("arst_irq", irq, 1'b0);
    chk("arst_rd_ts", rd_ts, 80'd0);
    step(2);
    rstn = 1'b1;
    step(2);
    chk("post_rst_valid", rd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptp_ts_queue_mc.md
# ptp_ts_queue_mc

Multi-channel PTP timestamp capture queue. It latches the real-time-clock timestamp when a frame parser (TX, RX, or additional ports) flags an event message. Captures from all channels are merged round-robin into one shared FIFO, which the host interface drains through a valid/ready pop port. It sits between the frame parsers, the RTC and the host interface, and replaces the single-entry per-direction timestamp registers with a queued, channel-scalable store that counts overflows.

## Interface
Parameters:
- NUM_CH, 2: number of capture channels (1..8); channel 0 = TX, channel 1 = RX by convention.
- DEPTH, 8: shared FIFO entries; power of two, 2..64.
- TS_W, 80: timestamp width ({48-bit seconds, 32-bit nanoseconds}).
- SEQ_W, 16: PTP sequenceId width.
- CH_W, derived = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  single clock domain.
- rstn  in  1  asynchronous active-low reset.
- cap_vld  in  NUM_CH  one-cycle capture strobe per channel.
- cap_msgtype  in  4*NUM_CH  PTP messageType per channel, sampled with cap_vld.
- cap_seq  in  SEQ_W*NUM_CH  sequenceId per channel, sampled with cap_vld.
- rtc_ts  in  TS_W  current RTC time.
- flush  in  1  synchronous clear of FIFO and holding registers.
- rd_ready  in  1  host accepts head entry.
- rd_valid  out  1  head entry valid (show-ahead).
- rd_ch  out  CH_W  channel of head entry.
- rd_msgtype  out  4  messageType of head entry.
- rd_seq  out  SEQ_W  sequenceId of head entry.
- rd_ts  out  TS_W  timestamp of head entry.
- fifo_level  out  clog2(DEPTH)+1  number of entries stored.
- ovf_clr  in  NUM_CH  per-channel clear pulse for ovf_sticky and drop_cnt.
- ovf_sticky  out  NUM_CH  channel has dropped at least one capture.
- drop_cnt  out  8*NUM_CH  per-channel saturating drop counter.
- irq  out  1  level: rd_valid OR (|ovf_sticky).

## Operation
- Each channel has a one-entry holding register {msgtype, seq, ts} plus hold_v. On cap_vld[c], the register loads cap_msgtype, cap_seq and rtc_ts from the same cycle.
- Arbiter: at most one push per cycle. It grants the first channel with hold_v=1, searching from rr_ptr upward with wrap. On a grant, rr_ptr = granted+1 (mod NUM_CH), and rr_ptr is unchanged when there is no grant. The push requires space, where space = (level<DEPTH) OR (rd_valid AND rd_ready).
- Holding register behaviour:
  - A granted holding register clears hold_v unless cap_vld arrives in the same cycle; in that case it reloads with the new capture, and no drop occurs.
  - cap_vld with hold_v=1 and no grant that cycle is a drop: the new capture is discarded, the held entry is kept, ovf_sticky[c] is set, and drop_cnt[c] increments, saturating at 255.
- ovf_clr[c] clears ovf_sticky[c] and drop_cnt[c]. If a drop happens in the same cycle, the result is sticky=1 and cnt=1.
- FIFO: circular buffer with read and write pointers and a level counter. A pop occurs when rd_valid AND rd_ready.
  - push only: level+1.
  - pop only: level−1.
  - push and pop together: level unchanged.
- flush clears every hold_v, both pointers, level and rr_ptr to 0. It does not affect ovf_sticky or drop_cnt. A cap_vld in the flush cycle is discarded and not counted.
- rd_* outputs show the head entry when rd_valid=1. Their values are don't-care when rd_valid=0.

## Timing
- Reset values: rd_valid=0, rd_ch=0, rd_msgtype=0, rd_seq=0, rd_ts=0, fifo_level=0, ovf_sticky=0, drop_cnt=0, irq=0, all hold_v=0, rr_ptr=0.
- Latency from cap_vld to rd_valid (empty FIFO, no contention): cap_vld in cycle N → hold_v=1 in N+1 → push at the end of N+1 → rd_valid=1 in N+2.
- The timestamp is rtc_ts from cycle N exactly; arbitration delay never changes the stored value.
- A pop at the end of cycle M updates the rd_* outputs to the next entry in M+1. Back-to-back pops sustain 1 entry per cycle.
- A full FIFO with a pop in the same cycle accepts a push. A full FIFO with no pop blocks the push, and the holding register stays valid.
- Worst-case backlog per channel is 1 holding entry; the system capacity is DEPTH+NUM_CH captures before a drop.
- fifo_level and irq are registered and update in the cycle after the push or pop edge.

## Test plan
- Single capture: rtc_ts=0x0000_0000_0005_1234_5678, cap_vld[1] with seq=0x00A7 and msgtype=0 → 2 cycles later rd_valid=1, rd_ch=1, rd_seq=0x00A7, rd_ts=0x...0005_1234_5678; pop → rd_valid=0, level=0.
- Simultaneous capture on channels 0 and 1 with rr_ptr=0 → FIFO order is ch0 then ch1. A second simultaneous pair then yields ch0, ch1 again (rr_ptr=0 after ch1 grant). With NUM_CH=4 and all four firing → order 0,1,2,3.
- Overflow, DEPTH=8, rd_ready=0, 10 captures on channel 0 spaced 2 cycles apart → level=8, hold_v=1, drop_cnt[0]=1, ovf_sticky[0]=1, irq=1. Pop one entry → the held capture enters with level back at 8.
- Saturation and clear: 300 drops on channel 1 → drop_cnt[1]=255. ovf_clr[1] with a coincident drop → sticky=1, cnt=1.
- Full FIFO with rd_ready=1 and a pending holding register → push and pop in the same cycle, level stays 8, no drop.
- Flush mid-operation with level=5 and hold_v on channel 0 → next cycle level=0, rd_valid=0, counters unchanged. Reset asserted asynchronously mid-burst → all outputs take their reset values immediately.
